dmem_arbiter: RTL and testbench

- Shares the single data-memory port (dmem) between two requesters: port 0 is the CPU MA stage, port 1 is a secondary master such as a program loader, DMA engine or debug unit.
- Round-robin arbitration serialises whole transactions; one transaction is in flight at a time.
- Each requester sees the same read/write/busywait protocol it would see on dmem directly.
- A watchdog aborts any transaction the memory never completes.

---
 rtl/dmem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single data-memory
// port. Whole transactions are serialised; a watchdog aborts any transaction
// the memory never completes.

// Per-requester side: request detect, stall generation and read-data gating.
module dmem_arb_port #(
  parameter int DW = 32
) (
  input  logic [3:0]    read,
  input  logic [2:0]    write,
  input  logic          sel,        // this port owns the memory this cycle
  input  logic          complete,   // memory finished or watchdog fired
  input  logic          abort,      // watchdog fired
  input  logic [DW-1:0] mem_rdata,
  output logic          req,
  output logic          busywait,
  output logic [DW-1:0] rdata
);

  logic done;

  // Stall the requester until its own transaction completes; an aborted
  // transaction hands back zero rather than whatever the bus holds.
  always_comb begin
    req      = read[3] | write[2];
    done     = sel & complete;
    busywait = req & ~done;
    rdata    = (sel & ~abort) ? mem_rdata : '0;
  end

endmodule

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            P0_READ,
  input  logic [2:0]            P0_WRITE,
  input  logic [ADDR_WIDTH-1:0] P0_ADDR,
  input  logic [DATA_WIDTH-1:0] P0_WDATA,
  output logic [DATA_WIDTH-1:0] P0_RDATA,
  output logic                  P0_BUSYWAIT,
  input  logic [3:0]            P1_READ,
  input  logic [2:0]            P1_WRITE,
  input  logic [ADDR_WIDTH-1:0] P1_ADDR,
  input  logic [DATA_WIDTH-1:0] P1_WDATA,
  output logic [DATA_WIDTH-1:0] P1_RDATA,
  output logic                  P1_BUSYWAIT,
  output logic [3:0]            MEM_READ,
  output logic [2:0]            MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic [1:0]            GRANT,
  output logic                  TIMEOUT_ERR
);

  localparam int NP = 2;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          owner;       // index of the port being served
  logic          last_grant;  // index of the port served most recently
  logic          winner;
  logic [CW-1:0] cnt;
  logic          serve;
  logic          timeout_hit;
  logic          complete;

  logic [NP-1:0][3:0]            rd_in;
  logic [NP-1:0][2:0]            wr_in;
  logic [NP-1:0][ADDR_WIDTH-1:0] addr_in;
  logic [NP-1:0][DATA_WIDTH-1:0] wdata_in;
  logic [NP-1:0][DATA_WIDTH-1:0] rdata_out;
  logic [NP-1:0]                 req;
  logic [NP-1:0]                 bw;
  logic [NP-1:0]                 sel;

  assign rd_in    = {P1_READ,  P0_READ};
  assign wr_in    = {P1_WRITE, P0_WRITE};
  assign addr_in  = {P1_ADDR,  P0_ADDR};
  assign wdata_in = {P1_WDATA, P0_WDATA};

  assign serve       = (state == ST_SERVE);
  assign timeout_hit = serve & (cnt == CNT_LAST) & MEM_BUSYWAIT;
  assign complete    = ~MEM_BUSYWAIT | timeout_hit;
  assign sel         = serve ? (owner ? 2'b10 : 2'b01) : 2'b00;

  for (genvar i = 0; i < NP; i++) begin : g_port
    dmem_arb_port #(.DW(DATA_WIDTH)) u_port (
      .read      (rd_in[i]),
      .write     (wr_in[i]),
      .sel       (sel[i]),
      .complete  (complete),
      .abort     (timeout_hit),
      .mem_rdata (MEM_RDATA),
      .req       (req[i]),
      .busywait  (bw[i]),
      .rdata     (rdata_out[i])
    );
  end

  assign P0_BUSYWAIT = bw[0];
  assign P1_BUSYWAIT = bw[1];
  assign P0_RDATA    = rdata_out[0];
  assign P1_RDATA    = rdata_out[1];
  assign GRANT       = sel;

  // Tie goes to the port that was not served last; a lone requester just wins.
  always_comb begin
    winner = 1'b0;
    if (req[0] & req[1]) winner = ~last_grant;
    else                 winner = req[1];
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state: RELEASE always burns one dead cycle so dmem cannot restart.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|req) state_nxt = ST_SERVE;
      ST_SERVE:   if (complete) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Owner and round-robin history are captured as SERVE is entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == ST_IDLE && |req) begin
      owner      <= winner;
      last_grant <= winner;
    end
  end

  // Watchdog: counts SERVE cycles; the sticky flag latches the first abort.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt         <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (state == ST_IDLE)  cnt <= '0;
      else if (serve && !complete) cnt <= cnt + 1'b1;
      if (timeout_hit) TIMEOUT_ERR <= 1'b1;
    end
  end

  // Memory side follows the owner combinationally during SERVE, quiet otherwise.
  always_comb begin
    MEM_READ  = '0;
    MEM_WRITE = '0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    if (serve) begin
      MEM_READ  = rd_in[owner];
      MEM_WRITE = wr_in[owner];
      MEM_ADDR  = addr_in[owner];
      MEM_WDATA = wdata_in[owner];
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small busywait memory model.
module tb_dmem_arbiter;

  logic        CLK, RST;
  logic [3:0]  P0_READ, P1_READ, MEM_READ;
  logic [2:0]  P0_WRITE, P1_WRITE, MEM_WRITE;
  logic [31:0] P0_ADDR, P0_WDATA, P0_RDATA, P1_ADDR, P1_WDATA, P1_RDATA;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        P0_BUSYWAIT, P1_BUSYWAIT, MEM_BUSYWAIT;
  logic [1:0]  GRANT;
  logic        TIMEOUT_ERR;

  int vecs = 0;
  int errs = 0;

  // memory model: busy for 'lat' cycles after a strobe appears
  int   lat = 1;
  logic force_busy = 1'b0;
  int   bcnt = 0;
  logic strobe;

  assign strobe       = MEM_READ[3] | MEM_WRITE[2];
  assign MEM_BUSYWAIT = strobe & (force_busy | (bcnt != lat));
  assign MEM_RDATA    = (MEM_ADDR == 32'h40) ? 32'hDEADBEEF : ~MEM_ADDR;

  always @(posedge CLK) bcnt <= (strobe && MEM_BUSYWAIT) ? bcnt + 1 : 0;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .P0_READ(P0_READ), .P0_WRITE(P0_WRITE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA),
    .P0_RDATA(P0_RDATA), .P0_BUSYWAIT(P0_BUSYWAIT),
    .P1_READ(P1_READ), .P1_WRITE(P1_WRITE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA),
    .P1_RDATA(P1_RDATA), .P1_BUSYWAIT(P1_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .GRANT(GRANT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL sim_guard: observed no finish, expected finish before 100000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    P0_READ = '0; P0_WRITE = '0; P0_ADDR = '0; P0_WDATA = '0;
    P1_READ = '0; P1_WRITE = '0; P1_ADDR = '0; P1_WDATA = '0;
    #12;
    // reset state
    chk("rst_grant", 32'(GRANT), 32'h0);
    chk("rst_mem_read", 32'(MEM_READ), 32'h0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'h0);
    chk("rst_terr", 32'(TIMEOUT_ERR), 32'h0);
    chk("rst_p0_bw", 32'(P0_BUSYWAIT), 32'h0);
    chk("rst_p0_rdata", P0_RDATA, 32'h0);
    P1_READ = 4'b1010;
    #1;
    chk("rst_p1_bw_follows_req", 32'(P1_BUSYWAIT), 32'h1);
    P1_READ = '0;
    cyc();
    RST = 1'b1;
    cyc();

    // P0 word read at 0x40, memory busy 3 cycles
    lat = 3;
    P0_READ = 4'b1010; P0_ADDR = 32'h40;
    #1;
    chk("t1_idle_bw", 32'(P0_BUSYWAIT), 32'h1);
    chk("t1_idle_mem_read", 32'(MEM_READ), 32'h0);
    cyc();
    chk("t1_c1_mem_read", 32'(MEM_READ), 32'hA);
    chk("t1_c1_mem_addr", MEM_ADDR, 32'h40);
    chk("t1_c1_grant", 32'(GRANT), 32'h1);
    chk("t1_c1_bw", 32'(P0_BUSYWAIT), 32'h1);
    cyc();
    chk("t1_c2_bw", 32'(P0_BUSYWAIT), 32'h1);
    cyc();
    chk("t1_c3_bw", 32'(P0_BUSYWAIT), 32'h1);
    cyc();
    chk("t1_done_bw", 32'(P0_BUSYWAIT), 32'h0);
    chk("t1_done_rdata", P0_RDATA, 32'hDEADBEEF);
    chk("t1_done_grant", 32'(GRANT), 32'h1);
    cyc();
    P0_READ = '0;
    chk("t1_rel_grant", 32'(GRANT), 32'h0);
    chk("t1_rel_mem_read", 32'(MEM_READ), 32'h0);
    chk("t1_rel_rdata", P0_RDATA, 32'h0);
    cyc();

    // P1 store byte to 0x13, P0 idle
    lat = 1;
    P1_WRITE = 3'b100; P1_ADDR = 32'h13; P1_WDATA = 32'hAB;
    #1;
    chk("t6_idle_p1_bw", 32'(P1_BUSYWAIT), 32'h1);
    chk("t6_idle_p0_bw", 32'(P0_BUSYWAIT), 32'h0);
    cyc();
    chk("t6_mem_write", 32'(MEM_WRITE), 32'h4);
    chk("t6_mem_addr", MEM_ADDR, 32'h13);
    chk("t6_mem_wdata", MEM_WDATA, 32'hAB);
    chk("t6_grant", 32'(GRANT), 32'h2);
    chk("t6_p1_bw", 32'(P1_BUSYWAIT), 32'h1);
    chk("t6_p0_bw", 32'(P0_BUSYWAIT), 32'h0);
    cyc();
    chk("t6_done_p1_bw", 32'(P1_BUSYWAIT), 32'h0);
    chk("t6_done_p0_bw", 32'(P0_BUSYWAIT), 32'h0);
    cyc();
    P1_WRITE = '0;
    chk("t6_rel_mem_write", 32'(MEM_WRITE), 32'h0);
    cyc();

    // simultaneous writes: P0 first (P1 was served last), then P1
    lat = 2;
    P0_WRITE = 3'b110; P0_ADDR = 32'h100; P0_WDATA = 32'h11;
    P1_WRITE = 3'b110; P1_ADDR = 32'h200; P1_WDATA = 32'h22;
    cyc();
    chk("t2_c1_grant", 32'(GRANT), 32'h1);
    chk("t2_c1_addr", MEM_ADDR, 32'h100);
    chk("t2_c1_wdata", MEM_WDATA, 32'h11);
    chk("t2_c1_p1_bw", 32'(P1_BUSYWAIT), 32'h1);
    cyc();
    chk("t2_c2_p1_bw", 32'(P1_BUSYWAIT), 32'h1);
    cyc();
    chk("t2_done_grant", 32'(GRANT), 32'h1);
    chk("t2_done_p0_bw", 32'(P0_BUSYWAIT), 32'h0);
    chk("t2_done_p1_bw", 32'(P1_BUSYWAIT), 32'h1);
    cyc();
    P0_WRITE = '0;
    chk("t2_rel_grant", 32'(GRANT), 32'h0);
    chk("t2_rel_p1_bw", 32'(P1_BUSYWAIT), 32'h1);
    cyc();
    chk("t2_idle_grant", 32'(GRANT), 32'h0);
    cyc();
    chk("t2_p1_grant", 32'(GRANT), 32'h2);
    chk("t2_p1_addr", MEM_ADDR, 32'h200);
    cyc();
    cyc();
    chk("t2_p1_done_bw", 32'(P1_BUSYWAIT), 32'h0);
    cyc();
    P1_WRITE = '0;
    cyc();

    // continuous contention: grants alternate starting with P0
    lat = 1;
    P0_READ = 4'b1010; P0_ADDR = 32'h40;
    P1_READ = 4'b1100; P1_ADDR = 32'h80;
    for (int t = 0; t < 6; t++) begin
      cyc();
      chk($sformatf("t3_grant_%0d", t), 32'(GRANT), (t % 2 == 0) ? 32'h1 : 32'h2);
      cyc();
      if (t % 2 == 0) begin
        chk($sformatf("t3_p0_bw_%0d", t), 32'(P0_BUSYWAIT), 32'h0);
        chk($sformatf("t3_p1_bw_%0d", t), 32'(P1_BUSYWAIT), 32'h1);
        chk($sformatf("t3_p0_rdata_%0d", t), P0_RDATA, 32'hDEADBEEF);
      end else begin
        chk($sformatf("t3_p1_bw_%0d", t), 32'(P1_BUSYWAIT), 32'h0);
        chk($sformatf("t3_p0_bw_%0d", t), 32'(P0_BUSYWAIT), 32'h1);
        chk($sformatf("t3_p1_rdata_%0d", t), P1_RDATA, 32'hFFFFFF7F);
      end
      cyc();
      chk($sformatf("t3_rel_grant_%0d", t), 32'(GRANT), 32'h0);
      cyc();
    end
    P0_READ = '0; P1_READ = '0;
    cyc();

    // watchdog: memory never completes, TIMEOUT=8
    force_busy = 1'b1;
    P0_READ = 4'b1010; P0_ADDR = 32'h40;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      chk($sformatf("t4_bw_c%0d", c), 32'(P0_BUSYWAIT), 32'h1);
    end
    cyc();
    chk("t4_abort_bw", 32'(P0_BUSYWAIT), 32'h0);
    chk("t4_abort_rdata", P0_RDATA, 32'h0);
    chk("t4_abort_grant", 32'(GRANT), 32'h1);
    chk("t4_abort_terr_pre", 32'(TIMEOUT_ERR), 32'h0);
    cyc();
    P0_READ = '0; force_busy = 1'b0;
    chk("t4_rel_terr", 32'(TIMEOUT_ERR), 32'h1);
    chk("t4_rel_grant", 32'(GRANT), 32'h0);
    cyc();
    P0_READ = 4'b1010;
    cyc();
    chk("t4_next_bw", 32'(P0_BUSYWAIT), 32'h1);
    cyc();
    chk("t4_next_done_bw", 32'(P0_BUSYWAIT), 32'h0);
    chk("t4_next_rdata", P0_RDATA, 32'hDEADBEEF);
    chk("t4_terr_sticky", 32'(TIMEOUT_ERR), 32'h1);
    cyc();
    P0_READ = '0;
    cyc();

    // asynchronous reset mid-SERVE of a P1 write
    lat = 3;
    P1_WRITE = 3'b110; P1_ADDR = 32'h300; P1_WDATA = 32'h33;
    cyc();
    chk("t5_grant", 32'(GRANT), 32'h2);
    chk("t5_mem_write", 32'(MEM_WRITE), 32'h6);
    cyc();
    #2 RST = 1'b0;
    #1;
    chk("t5_async_grant", 32'(GRANT), 32'h0);
    chk("t5_async_mem_write", 32'(MEM_WRITE), 32'h0);
    chk("t5_async_terr", 32'(TIMEOUT_ERR), 32'h0);
    chk("t5_async_p1_bw", 32'(P1_BUSYWAIT), 32'h1);
    P1_WRITE = '0;
    cyc();
    RST = 1'b1;
    lat = 1;
    P0_READ = 4'b1010; P0_ADDR = 32'h40;
    P1_READ = 4'b1010; P1_ADDR = 32'h80;
    cyc();
    chk("t5_tie_grant", 32'(GRANT), 32'h1);
    cyc();
    chk("t5_tie_p0_bw", 32'(P0_BUSYWAIT), 32'h0);
    cyc();
    P0_READ = '0; P1_READ = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
